// File: rtl/phase_restore_pkg.sv
// Shared OS PFB definitions: default frame geometry, shift schedule step and read FSM states.
package phase_restore_pkg;

  localparam int FFT_LEN_DEF  = 8;
  localparam int DEC_RATE_DEF = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // s_next = (s - (M - D)) mod M, written as an addition so nothing goes negative
  function automatic int unsigned next_shift(int unsigned s, int unsigned m, int unsigned d);
    return (s + m - ((m - d) % m)) % m;
  endfunction

endpackage

// File: rtl/phase_restore_if.sv
// Sample stream bundle: compensated-order input side and natural-order output side.
interface phase_restore_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_last;

  modport master (output din, din_valid, input dout, dout_valid, dout_last);
  modport slave  (input din, din_valid, output dout, dout_valid, dout_last);
endinterface

// File: rtl/phase_restore_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// The read register resets to zero so downstream outputs start from a known value.
module sdp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/phase_restore.sv
// Undoes the OS PFB phase compensation: scatter-writes each reversed, shifted frame into a
// ping-pong RAM and drains it in natural order; output appears 2 edges after the last input.
module phase_restore
  import phase_restore_pkg::*;
#(
  parameter int FFT_LEN  = FFT_LEN_DEF,
  parameter int DEC_RATE = DEC_RATE_DEF,
  parameter int WIDTH    = 16
) (
  input logic            clk,
  input logic            rst,
  phase_restore_if.slave io
);

  localparam int LG = $clog2(FFT_LEN);
  localparam logic [LG-1:0] LAST = LG'(FFT_LEN - 1);

  logic [LG-1:0] r_n;
  logic          r_wbank;
  logic [LG-1:0] r_shift;
  logic [1:0]    r_rdy;
  rd_state_t     r_state;
  logic          r_rbank;
  logic [LG-1:0] r_raddr;
  logic          r_vld;
  logic          r_last;

  logic          w_wlast;
  logic [LG-1:0] w_woff;
  logic          w_ren;
  logic          w_pick;
  logic [1:0]    w_rdy_set;
  logic [1:0]    w_rdy_clr;
  logic [WIDTH-1:0] w_rdata;

  assign w_wlast   = io.din_valid && (r_n == LAST);
  assign w_woff    = r_shift - LG'(1) - r_n;
  assign w_ren     = (r_state == DRAIN);
  assign w_pick    = ~r_rdy[0];
  assign w_rdy_set = {w_wlast & r_wbank, w_wlast & ~r_wbank};

  // Flags clear when the drain of that bank is launched, either from IDLE or chained.
  always_comb begin
    w_rdy_clr = 2'b00;
    if (r_state == IDLE && (|r_rdy)) begin
      w_rdy_clr[w_pick] = 1'b1;
    end else if (r_state == DRAIN && r_raddr == LAST && r_rdy[~r_rbank]) begin
      w_rdy_clr[~r_rbank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n     <= '0;
      r_wbank <= 1'b0;
      r_shift <= '0;
      r_rdy   <= 2'b00;
      r_state <= IDLE;
      r_rbank <= 1'b0;
      r_raddr <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_vld  <= w_ren;
      r_last <= w_ren && (r_raddr == LAST);
      r_rdy  <= (r_rdy & ~w_rdy_clr) | w_rdy_set;

      if (io.din_valid) begin
        r_n <= r_n + LG'(1);
        if (r_n == LAST) begin
          r_wbank <= ~r_wbank;
          r_shift <= LG'(next_shift(32'(r_shift), FFT_LEN, DEC_RATE));
        end
      end

      case (r_state)
        IDLE: begin
          if (|r_rdy) begin
            r_state <= DRAIN;
            r_rbank <= w_pick;
            r_raddr <= '0;
          end
        end
        DRAIN: begin
          r_raddr <= r_raddr + LG'(1);
          if (r_raddr == LAST) begin
            if (r_rdy[~r_rbank]) r_rbank <= ~r_rbank;
            else                 r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sdp_ram #(
    .DEPTH(2 * FFT_LEN),
    .WIDTH(WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (io.din_valid),
    .i_waddr ({r_wbank, w_woff}),
    .i_wdata (io.din),
    .i_re    (w_ren),
    .i_raddr ({r_rbank, r_raddr}),
    .o_rdata (w_rdata)
  );

  assign io.dout       = w_rdata;
  assign io.dout_valid = r_vld;
  assign io.dout_last  = r_last;

endmodule

// File: tb/tb_phase_restore.sv
// Scoreboard bench for phase_restore with M=8, D=6: directed frames, gaps, and resets.
module tb_phase_restore;

  localparam int M = 8;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] dat;
    logic         last;
  } exp_t;

  typedef logic [W-1:0] frame_t [M];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_restore_if #(.WIDTH(W)) bus ();

  phase_restore #(
    .FFT_LEN (M),
    .DEC_RATE(6),
    .WIDTH   (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   out_cnt  = 0;
  int   run      = 0;
  int   last_run = 0;
  int   tb_s     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected sample per valid output and tracks contiguous valid runs
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      run++;
      out_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: dout=%0d appeared with nothing expected", bus.dout);
      end else begin
        mon_e = sb.pop_front();
        check("dout", 32'(bus.dout), 32'(mon_e.dat));
        check("dout_last", 32'(bus.dout_last), 32'(mon_e.last));
      end
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic drive(input logic [W-1:0] v, input bit gap);
    bus.din       = v;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic encode(input frame_t x, output frame_t z);
    for (int n = 0; n < M; n++) z[n] = x[(tb_s - 1 - n + 2 * M) % M];
  endtask

  task automatic ramp(input int base, output frame_t x);
    for (int i = 0; i < M; i++) x[i] = W'(base + i);
  endtask

  task automatic send_frame(input frame_t z, input frame_t x, input bit gap);
    exp_t e;
    for (int i = 0; i < M; i++) drive(z[i], gap && (i != M - 1));
    for (int i = 0; i < M; i++) begin
      e.dat  = x[i];
      e.last = (i == M - 1);
      sb.push_back(e);
    end
    tb_s = (tb_s + M - 2) % M;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tb_s = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d samples pending expected 0", name, sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  frame_t x, z;
  frame_t z0 = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
  frame_t z1 = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd7, 16'd6};
  int base_cnt;
  int guard;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_last", 32'(bus.dout_last), 0);

    // Frame 0 (s=0) with latency probe, then frame 1 (s=6)
    ramp(0, x);
    send_frame(z0, x, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("lat_edge1_valid", 32'(bus.dout_valid), 0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(bus.dout_valid), 1);
    send_frame(z1, x, 1'b0);
    wait_drain("frame1");
    check("dout_hold", 32'(bus.dout), 7);

    // Five back-to-back frames, shifts 0,6,4,2,0
    do_reset();
    for (int f = 0; f < 5; f++) begin
      ramp(16 * f, x);
      encode(x, z);
      send_frame(z, x, 1'b0);
    end
    wait_drain("five_frames");
    check("five_frames_run", 32'(last_run), 40);

    // Gappy input: same output, contiguous drain
    do_reset();
    ramp(0, x);
    send_frame(z0, x, 1'b1);
    wait_drain("gappy");
    check("gappy_run", 32'(last_run), 8);

    // Reset three samples into frame 1, then a fresh frame 0
    for (int i = 0; i < 3; i++) drive(z1[i], 1'b0);
    do_reset();
    @(negedge clk);
    check("midframe_rst_valid", 32'(bus.dout_valid), 0);
    send_frame(z0, x, 1'b0);
    wait_drain("fresh");
    check("fresh_run", 32'(last_run), 8);

    // Reset while draining, once four samples have been seen
    ramp(100, x);
    encode(x, z);
    base_cnt = out_cnt;
    send_frame(z, x, 1'b0);
    guard = 0;
    while (out_cnt < base_cnt + 4 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_reached4", 32'(out_cnt - base_cnt), 4);
    do_reset();
    @(negedge clk);
    check("drain_rst_valid", 32'(bus.dout_valid), 0);
    repeat (20) @(negedge clk);
    check("drain_rst_count", 32'(out_cnt - base_cnt), 5);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
